// File: rtl/mux_pkg.sv
//------------------------------------------------------------------------------
// mux_pkg : shared selection-mode codes and a constant clog2 for arb_mux.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, first requester at or after ptr.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int v_idx;

    // Scan from the far end back toward ptr so the closest requester wins last.
    always_comb begin
        gnt_idx = '0;
        v_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            v_idx = int'(ptr) + k;
            if (v_idx >= N) begin
                v_idx = v_idx - N;
            end
            if (req[v_idx]) begin
                gnt_idx = SEL_W'(v_idx);
            end
        end
    end

    assign gnt_any = |req;

endmodule

`default_nettype wire

// File: rtl/arb_mux.sv
//------------------------------------------------------------------------------
// arb_mux : N-channel arbitrating mux with a one-beat registered output stage.
// Optional feature macro: ARB_MUX_STATS_EN (adds xfer_cnt transfer counter).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_mux
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 1,
    parameter int SEL_W = (N > 1) ? clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_ch
`ifdef ARB_MUX_STATS_EN
    ,
    output logic [31:0]        xfer_cnt
`endif
);

    localparam int PAD = 1 << SEL_W;

    logic             w_accept;
    logic             w_gnt_valid;
    logic             w_xfer;
    logic [SEL_W-1:0] w_g;
    logic [WIDTH-1:0] w_ch [PAD];

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_ch;

    // Channel table padded to a power of two so any select value is a legal index.
    genvar gi;
    generate
        for (gi = 0; gi < PAD; gi++) begin : g_ch
            if (gi < N) begin : g_live
                assign w_ch[gi] = in_data[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_ch[gi] = '0;
            end
        end
    endgenerate

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_ptr;
            logic             w_sel_unused;

            rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
                .req     (in_valid),
                .ptr     (r_ptr),
                .gnt_idx (w_g),
                .gnt_any (w_gnt_valid)
            );

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ptr <= '0;
                end else if (w_xfer) begin
                    r_ptr <= (w_g == SEL_W'(N - 1)) ? '0 : w_g + SEL_W'(1);
                end
            end

            assign w_sel_unused = ^in_sel;
        end else begin : g_fixed
            logic [PAD-1:0] w_valid_pad;

            assign w_valid_pad = PAD'(in_valid);
            assign w_g         = in_sel;
            assign w_gnt_valid = ({1'b0, in_sel} < (SEL_W + 1)'(N)) && w_valid_pad[in_sel];
        end
    endgenerate

    assign w_accept = !r_out_valid || out_ready;
    assign w_xfer   = w_gnt_valid && w_accept && !reset;
    assign in_ready = w_xfer ? (N'(1) << w_g) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_ch[w_g];
            r_out_ch    <= w_g;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;

`ifdef ARB_MUX_STATS_EN
    logic [31:0] r_xfer_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xfer_cnt <= '0;
        end else if (w_xfer) begin
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arb_mux.sv
//------------------------------------------------------------------------------
// tb_arb_mux : directed self-checking bench for arb_mux (RR N=4, RR N=3, fixed N=5).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_arb_mux;

    logic clk;
    logic reset;

    // Round-robin, N=4, WIDTH=32
    logic [127:0] a_data;
    logic [3:0]   a_valid, a_ready;
    logic [1:0]   a_sel, a_ch;
    logic [31:0]  a_out;
    logic         a_ov, a_or;

    // Round-robin, N=3, WIDTH=8
    logic [23:0]  b_data;
    logic [2:0]   b_valid, b_ready;
    logic [1:0]   b_sel, b_ch;
    logic [7:0]   b_out;
    logic         b_ov, b_or;

    // Fixed select, N=5, WIDTH=32
    logic [159:0] c_data;
    logic [4:0]   c_valid, c_ready;
    logic [2:0]   c_sel, c_ch;
    logic [31:0]  c_out;
    logic         c_ov, c_or;

`ifdef ARB_MUX_STATS_EN
    logic [31:0]  a_cnt, b_cnt, c_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    arb_mux #(.WIDTH(32), .N(4), .MODE(1)) u_rr4 (
        .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .in_sel(a_sel), .out_data(a_out), .out_valid(a_ov),
        .out_ready(a_or), .out_ch(a_ch)
`ifdef ARB_MUX_STATS_EN
        , .xfer_cnt(a_cnt)
`endif
    );

    arb_mux #(.WIDTH(8), .N(3), .MODE(1)) u_rr3 (
        .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .in_sel(b_sel), .out_data(b_out), .out_valid(b_ov),
        .out_ready(b_or), .out_ch(b_ch)
`ifdef ARB_MUX_STATS_EN
        , .xfer_cnt(b_cnt)
`endif
    );

    arb_mux #(.WIDTH(32), .N(5), .MODE(0)) u_fix5 (
        .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_ready), .in_sel(c_sel), .out_data(c_out), .out_valid(c_ov),
        .out_ready(c_or), .out_ch(c_ch)
`ifdef ARB_MUX_STATS_EN
        , .xfer_cnt(c_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        a_data  = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        a_valid = 4'b1111; a_sel = 2'd0; a_or = 1'b1;
        b_data  = {8'hC2, 8'hB1, 8'hA0};
        b_valid = 3'b000;  b_sel = 2'd0; b_or = 1'b1;
        c_data  = '0;
        c_valid = 5'b00000; c_sel = 3'd0; c_or = 1'b1;

        // Reset state, with requests already pending
        tick();
        tick();
        check("rst_out_valid", 64'(a_ov), 64'd0);
        check("rst_out_data",  64'(a_out), 64'd0);
        check("rst_out_ch",    64'(a_ch), 64'd0);
        check("rst_in_ready",  64'(a_ready), 64'd0);

        // Round robin N=4, all valid: 0,1,2,3,0 one per cycle
        reset = 1'b0;
        #1;
        check("rr4_first_ready", 64'(a_ready), 64'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr4_ch%0d", k), 64'(a_ch), 64'(k % 4));
            check($sformatf("rr4_data%0d", k), 64'(a_out), 64'(32'h1000_0000 + (k % 4)));
            check($sformatf("rr4_valid%0d", k), 64'(a_ov), 64'd1);
        end

        // Round robin N=3, valid=101: 0,2,0,2 with ptr wrap 2->0
        b_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr3_ch%0d", k), 64'(b_ch), (k % 2 == 0) ? 64'd0 : 64'd2);
            check($sformatf("rr3_data%0d", k), 64'(b_out), (k % 2 == 0) ? 64'hA0 : 64'hC2);
        end
        b_valid = 3'b000;

        // Backpressure on N=4 (ptr=1 after last grant of ch0)
        a_valid = 4'b0000;
        tick();
        check("bp_drained", 64'(a_ov), 64'd0);
        a_valid = 4'b0100;
        a_or    = 1'b0;
        tick();
        check("bp_load_ch", 64'(a_ch), 64'd2);
        a_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_hold_data%0d", k), 64'(a_out), 64'h1000_0002);
            check($sformatf("bp_hold_valid%0d", k), 64'(a_ov), 64'd1);
            check($sformatf("bp_hold_ready%0d", k), 64'(a_ready), 64'd0);
        end
        a_or = 1'b1;
        #1;
        check("bp_release_ready", 64'(a_ready), 64'b1000);
        tick();
        check("bp_swap_valid", 64'(a_ov), 64'd1);
        check("bp_swap_ch",    64'(a_ch), 64'd3);
        check("bp_swap_data",  64'(a_out), 64'h1000_0003);

        // Fixed select N=5
        c_data  = {32'h5555_0004, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
        c_sel   = 3'd2;
        c_valid = 5'b00100;
        #1;
        check("fix_ready_sel2", 64'(c_ready), 64'b00100);
        tick();
        check("fix_data_sel2", 64'(c_out), 64'hDEAD_BEEF);
        check("fix_ch_sel2",   64'(c_ch), 64'd2);
        c_sel   = 3'd5;
        c_valid = 5'b11111;
        #1;
        check("fix_ready_sel5", 64'(c_ready), 64'd0);
        tick();
        check("fix_drain_sel5", 64'(c_ov), 64'd0);
        c_sel = 3'd4;
        #1;
        check("fix_ready_sel4", 64'(c_ready), 64'b10000);
        tick();
        check("fix_ch_sel4",   64'(c_ch), 64'd4);
        check("fix_data_sel4", 64'(c_out), 64'h5555_0004);
        c_sel = 3'd1;
        c_valid = 5'b00001;
        #1;
        check("fix_ready_novalid", 64'(c_ready), 64'd0);

        // Asynchronous reset between edges while a beat is held
        a_or = 1'b0;
        tick();
        check("arst_pre_valid", 64'(a_ov), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(a_ov), 64'd0);
        check("arst_data",  64'(a_out), 64'd0);
        check("arst_ch",    64'(a_ch), 64'd0);
        check("arst_ready", 64'(a_ready), 64'd0);
        #1;
        reset = 1'b0;
        a_or  = 1'b1;
        #1;
        check("arst_first_ready", 64'(a_ready), 64'b0001);
        tick();
        check("arst_first_ch", 64'(a_ch), 64'd0);

`ifdef ARB_MUX_STATS_EN
        for (int k = 0; k < 9; k++) begin
            tick();
        end
        check("stats_cnt10", 64'(a_cnt), 64'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
